// File: rtl/plru_pkg.sv
// Shared helpers for the tree pseudo-LRU replacement unit: width helper and
// heap-index / path-direction functions for walking a way's path from the root.
package plru_pkg;

    localparam int PLRU_MAX_WAYS = 16;

    function automatic int plru_clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

    // Heap index of the node that way sits under at the given depth (root = depth 0).
    function automatic int node_of(input int way, input int depth, input int way_w);
        return (1 << depth) | (way >> (way_w - depth));
    endfunction

    // Which child (0 = lower ways, 1 = upper ways) the way lies under at the given depth.
    function automatic logic dir_of(input int way, input int depth, input int way_w);
        return logic'((way >> (way_w - 1 - depth)) & 1);
    endfunction

endpackage

// File: rtl/plru_tree_select.sv
// Combinational victim chooser: lowest free invalid way first, else a tree walk
// that steers around fully locked subtrees (locks ignored when every way is locked).
module plru_tree_select
    import plru_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int WAY_W = plru_clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree,
    input  logic [WAYS-1:0]  valid_mask,
    input  logic [WAYS-1:0]  lock_mask,
    output logic [WAY_W-1:0] way,
    output logic             all_locked
);

    always_comb begin : select_walk
        logic [2*WAYS-1:1] sub_locked;
        logic [WAYS-1:0]   free;
        logic              found;
        logic              dir;
        int                node;

        sub_locked = '0;
        free       = ~valid_mask & ~lock_mask;
        found      = 1'b0;
        dir        = 1'b0;
        node       = 1;
        way        = '0;
        all_locked = &lock_mask;

        // Leaves occupy heap slots WAYS..2*WAYS-1; each internal node is locked
        // only when both of its children are.
        for (int i = WAYS; i < 2 * WAYS; i++) begin
            sub_locked[i] = lock_mask[i-WAYS];
        end
        for (int i = WAYS - 1; i >= 1; i--) begin
            sub_locked[i] = sub_locked[2*i] & sub_locked[2*i+1];
        end

        for (int w = 0; w < WAYS; w++) begin
            if (free[w] && !found) begin
                found = 1'b1;
                way   = WAY_W'(w);
            end
        end

        if (!found) begin
            for (int d = 0; d < WAY_W; d++) begin
                dir = tree[node-1];
                if (!all_locked && sub_locked[2*node+int'(dir)]) begin
                    dir = ~dir;
                end
                node = 2 * node + int'(dir);
            end
            way = WAY_W'(node - WAYS);
        end
    end

endmodule

// File: rtl/plru_tree_nway.sv
// Per-set tree pseudo-LRU state with hit/fill update, same-set forwarding into
// the victim query, and registered victim outputs.
module plru_tree_nway
    import plru_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 64,
    localparam int WAY_W = plru_clog2(WAYS),
    localparam int SET_W = plru_clog2(SETS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             query_valid,
    input  logic [SET_W-1:0] query_set,
    input  logic [WAYS-1:0]  valid_mask,
    input  logic [WAYS-1:0]  lock_mask,
    input  logic             upd_en,
    input  logic [SET_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    output logic             all_locked
);

    logic [WAYS-2:0]  tree_q [SETS];
    logic [WAYS-2:0]  upd_tree;
    logic [WAYS-2:0]  sel_tree;
    logic [WAY_W-1:0] sel_way;
    logic             sel_all_locked;

    // Every node on the accessed way's path is pointed away from that way.
    always_comb begin
        upd_tree = tree_q[upd_set];
        for (int d = 0; d < WAY_W; d++) begin
            upd_tree[node_of(int'(upd_way), d, WAY_W) - 1] = ~dir_of(int'(upd_way), d, WAY_W);
        end
    end

    always_comb begin
        sel_tree = tree_q[query_set];
        if (upd_en && (upd_set == query_set)) begin
            sel_tree = upd_tree;
        end
    end

    plru_tree_select #(
        .WAYS (WAYS)
    ) u_select (
        .tree       (sel_tree),
        .valid_mask (valid_mask),
        .lock_mask  (lock_mask),
        .way        (sel_way),
        .all_locked (sel_all_locked)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else if (upd_en) begin
            tree_q[upd_set] <= upd_tree;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            victim_valid <= 1'b0;
            victim_way   <= '0;
            all_locked   <= 1'b0;
        end else begin
            victim_valid <= query_valid;
            if (query_valid) begin
                victim_way <= sel_way;
                all_locked <= sel_all_locked;
            end
        end
    end

endmodule

// File: doc/plru_tree_nway.md
# plru_tree_nway

Parametrised tree pseudo-LRU replacement unit for the set-associative I/D caches. It holds one (WAYS-1)-bit PLRU tree per set and updates the selected set's tree on every hit or fill. It returns a registered victim way per query, preferring invalid ways and steering around locked ways. It is the N-way, multi-set successor of the fixed 4-way single-set replacement logic and sits beside the tag array in each cache controller.

## Interface
- WAYS, 4, associativity; power of two, 2..16
- SETS, 64, number of sets; power of two, >= 1
- WAY_W, derived $clog2(WAYS) (min 1), way index width
- SET_W, derived $clog2(SETS) (min 1), set index width

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- query_valid  in  1  victim request this cycle
- query_set  in  SET_W  set being queried
- valid_mask  in  WAYS  per-way valid bits of query_set, from the tag array
- lock_mask  in  WAYS  1 = way must not be chosen
- upd_en  in  1  access (hit or fill) this cycle
- upd_set  in  SET_W  set accessed
- upd_way  in  WAY_W  way accessed
- victim_valid  out  1  victim_way/all_locked valid this cycle
- victim_way  out  WAY_W  chosen victim
- all_locked  out  1  every way locked; victim_way is the unmasked PLRU choice

## Operation
- State: SETS x (WAYS-1) flops, heap-indexed. Node 1 is the root. Node i has children 2i and 2i+1. Leaf way w sits under node (WAYS+w)/2.
- Node bit 0 steers the victim search to the lower-way subtree. Node bit 1 steers it to the upper-way subtree.
- Update (upd_en=1): on every node along upd_way's path in upd_set, write the bit to point away from upd_way. For each node, the bit equals the complement of the upd_way bit at that depth. Nodes off the path are unchanged.
- Victim selection, in priority order:
  - Invalid first: if any way has valid_mask=0 and lock_mask=0, choose the lowest-index such way.
  - Tree walk: starting at the root, follow the node bit. If the chosen subtree is entirely locked, take the other subtree.
  - All locked: if every way is locked, do a plain tree walk ignoring locks and assert all_locked.
- Forwarding: if query_valid and upd_en are both set with query_set == upd_set, the victim is computed from the post-update tree.
- Upd and query for different sets are independent and may occur in the same cycle.
- valid_mask and lock_mask are sampled only in the query cycle.

## Timing
- Query latency is 1 cycle. Query at cycle t gives victim_valid=1 at t+1, with victim_way and all_locked held until the next query result. victim_valid pulses for one cycle per query.
- Back-to-back queries are accepted every cycle. There is no stall and no backpressure.
- An update becomes visible to a query in the same cycle (forwarded) and to all later cycles.
- Reset (resetn=0, async assert, release synchronised to clk by the top level):
  - all tree bits = 0
  - victim_valid = 0
  - victim_way = 0
  - all_locked = 0
- Reset mid-query: a victim_valid pending from the pre-reset query is dropped.
- Out-of-range upd_way cannot occur because WAYS is a power of two. WAYS=2 gives a single root bit.

## Structure
- plru_pkg: clog2 helper, way/set width localparams, node-index and path-bit functions (node_of(way, depth), dir_of(way, depth)).
- Sub-module plru_tree_select: purely combinational. It takes a tree, valid_mask and lock_mask and produces way and all_locked. The same instance serves both forwarded and stored trees via a mux on its input.
- Top module contains the state array, the update path decoder, the forward mux and the output registers.

## Test plan
Configuration is WAYS=4, SETS=4, with valid_mask=1111 and lock_mask=0000 unless stated.
- Reset then query set 0 -> cycle+1: victim_valid=1, victim_way=0, all_locked=0.
- Update set 0 ways 0, 2, 1 in turn, querying after each -> victims 2, 1, 3. Then query set 1 -> 0, showing set isolation.
- valid_mask=1011 on set 0 after reset -> victim 2. valid_mask=1011 with lock_mask=0100 -> PLRU choice 0.
- After reset, lock_mask=0011 -> victim 2. lock_mask=1111 -> victim 0 with all_locked=1.
- Same cycle upd_en (set 2, way 0) and query set 2 -> victim 2, i.e. the forwarded result, not 0.
- Assert resetn=0 in the cycle after a query -> victim_valid=0 and all trees cleared. The next query returns 0.
